// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: skewed-feed sequencer from per-lane operand SRAM banks to the PE array edge.
// A start command issues LEN consecutive reads on lane 0. Lane i replays lane i-1 one cycle later,
// which forms the diagonal wavefront. Returned data is qualified per lane after READ_LAT cycles.
// Build option: define SYSTOLIC_FEED_ZERO_GATE_EN to zero data_out[i] whenever en_out[i] is low.
//
// Handshake: start is sampled only in IDLE, and a start seen while busy is dropped.
// busy is high from the cycle after acceptance through the done cycle. done pulses for exactly
// one cycle. stall freezes issue, drain and skew progress and masks rd_en for that cycle.
// Reads that are already in flight still complete.
module systolic_feed_ctrl #(
    parameter int LANES    = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int LEN_W    = 16,
    parameter int READ_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [LEN_W-1:0]         len,
    input  logic                     acc_clr,
    input  logic                     stall,
    output logic                     busy,
    output logic                     done,
    output logic [LANES-1:0]         rd_en,
    output logic [LANES*ADDR_W-1:0]  rd_addr,
    input  logic [LANES*DATA_W-1:0]  rd_data,
    output logic [LANES-1:0]         en_out,
    output logic [LANES-1:0]         cmen_out,
    output logic [LANES*DATA_W-1:0]  data_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int DRAIN_N = LANES - 1 + READ_LAT;
    localparam int CNT_W   = $clog2(DRAIN_N + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_N - 1);

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    k;
    logic [CNT_W-1:0]    drain_cnt;

    // Lane 0 issue registers. These are the head of the skew chain.
    logic                en0;
    logic                cm0;
    logic [ADDR_W-1:0]   addr0;

    logic [LANES-1:0]    lane_en;
    logic [LANES-1:0]    lane_cm;
    logic [ADDR_W-1:0]   lane_addr [LANES];
    logic [LANES-1:0]    rd_cm;

    logic [LANES-1:0]    en_pipe [READ_LAT];
    logic [LANES-1:0]    cm_pipe [READ_LAT];

    // Command FSM. It also owns lane 0 issue, busy and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            k         <= '0;
            drain_cnt <= '0;
            en0       <= 1'b0;
            cm0       <= 1'b0;
            addr0     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        len_q  <= len;
                        busy   <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // Beat 0 is loaded here. If stall is high, rd_en stays masked until it drops.
                            state <= ISSUE;
                            en0   <= 1'b1;
                            addr0 <= base_addr;
                            cm0   <= acc_clr;
                            k     <= LEN_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        if (k == len_q) begin
                            en0       <= 1'b0;
                            cm0       <= 1'b0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            // Address arithmetic wraps modulo 2^ADDR_W.
                            en0   <= 1'b1;
                            cm0   <= 1'b0;
                            addr0 <= base_q + ADDR_W'(k);
                            k     <= k + LEN_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lane_en[0]   = en0;
    assign lane_cm[0]   = cm0;
    assign lane_addr[0] = addr0;

    for (genvar g = 1; g < LANES; g++) begin : g_skew
        logic              e_q;
        logic              c_q;
        logic [ADDR_W-1:0] a_q;

        // Skew stage g copies stage g-1 on every non-stalled cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                e_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
            end else if (!stall) begin
                e_q <= lane_en[g-1];
                c_q <= lane_cm[g-1];
                a_q <= lane_addr[g-1];
            end
        end

        assign lane_en[g]   = e_q;
        assign lane_cm[g]   = c_q;
        assign lane_addr[g] = a_q;
    end

    assign rd_en = lane_en & {LANES{~stall}};
    assign rd_cm = lane_cm & rd_en;

    // Read-latency pipe. It ignores stall so that issued reads still get qualified.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < READ_LAT; j++) begin
                en_pipe[j] <= '0;
                cm_pipe[j] <= '0;
            end
        end else begin
            en_pipe[0] <= rd_en;
            cm_pipe[0] <= rd_cm;
            for (int j = 1; j < READ_LAT; j++) begin
                en_pipe[j] <= en_pipe[j-1];
                cm_pipe[j] <= cm_pipe[j-1];
            end
        end
    end

    assign en_out   = en_pipe[READ_LAT-1];
    assign cmen_out = cm_pipe[READ_LAT-1];

    for (genvar g = 0; g < LANES; g++) begin : g_lane_out
        assign rd_addr[g*ADDR_W +: ADDR_W] = lane_addr[g];
`ifdef SYSTOLIC_FEED_ZERO_GATE_EN
        assign data_out[g*DATA_W +: DATA_W] = en_out[g] ? rd_data[g*DATA_W +: DATA_W] : '0;
`else
        assign data_out[g*DATA_W +: DATA_W] = rd_data[g*DATA_W +: DATA_W];
`endif
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl. Cycle numbers are relative to the cycle in which
// start is driven (cycle 0). Lane 0 and lane 7 read addresses go through an expected queue.
module tb_systolic_feed_ctrl;
  localparam int LANES    = 8;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 16;
  localparam int LEN_W    = 16;
  localparam int READ_LAT = 1;
  localparam logic [DATA_W-1:0] PAT = 32'hDEADBEEF;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [ADDR_W-1:0]       base_addr;
  logic [LEN_W-1:0]        len;
  logic                    acc_clr;
  logic                    stall;
  logic                    busy;
  logic                    done;
  logic [LANES-1:0]        rd_en;
  logic [LANES*ADDR_W-1:0] rd_addr;
  logic [LANES*DATA_W-1:0] rd_data;
  logic [LANES-1:0]        en_out;
  logic [LANES-1:0]        cmen_out;
  logic [LANES*DATA_W-1:0] data_out;

  systolic_feed_ctrl #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .acc_clr(acc_clr), .stall(stall), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .en_out(en_out), .cmen_out(cmen_out),
    .data_out(data_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t0 = 0;
  bit rec_on = 1'b0;

  logic [ADDR_W-1:0] exp_q0[$];
  logic [ADDR_W-1:0] exp_q7[$];

  logic [63:0] rec_rd0, rec_rd7, rec_en0, rec_en7, rec_cm7, rec_busy, rec_done, rec_any;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // scoreboard / recorder
  always @(negedge clk) begin : monitor
    int rel;
    logic [63:0] e;
    rel = cyc - t0;
    if (rec_on && rel >= 0 && rel < 64) begin
      rec_rd0[rel]  = rd_en[0];
      rec_rd7[rel]  = rd_en[7];
      rec_en0[rel]  = en_out[0];
      rec_en7[rel]  = en_out[7];
      rec_cm7[rel]  = cmen_out[7];
      rec_busy[rel] = busy;
      rec_done[rel] = done;
      rec_any[rel]  = |{busy, done, rd_en, en_out, cmen_out, rd_addr};
    end
    if (rd_en[0]) begin
      e = 'x;
      if (exp_q0.size() > 0) e = 64'(exp_q0.pop_front());
      chk("lane0_addr", 64'(rd_addr[0 +: ADDR_W]), e);
    end
    if (rd_en[7]) begin
      e = 'x;
      if (exp_q7.size() > 0) e = 64'(exp_q7.pop_front());
      chk("lane7_addr", 64'(rd_addr[7*ADDR_W +: ADDR_W]), e);
    end
    for (int i = 0; i < LANES; i++) begin
      if (en_out[i]) chk("beat_data", 64'(data_out[i*DATA_W +: DATA_W]), 64'(PAT));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_cmd(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l, input logic a);
    logic [ADDR_W-1:0] ad;
    rec_rd0 = '0; rec_rd7 = '0; rec_en0 = '0; rec_en7 = '0;
    rec_cm7 = '0; rec_busy = '0; rec_done = '0; rec_any = '0;
    tick();
    start = 1'b1; base_addr = b; len = l; acc_clr = a;
    t0 = cyc;
    rec_on = 1'b1;
    for (int k = 0; k < int'(l); k++) begin
      ad = b + ADDR_W'(k);
      exp_q0.push_back(ad);
      exp_q7.push_back(ad);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_to(input int r);
    while (cyc - t0 < r) tick();
  endtask

  initial begin
    logic [DATA_W-1:0] exp_idle;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; acc_clr = 1'b0; stall = 1'b0;
    rd_data = {LANES{PAT}};
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rd_en", 64'(rd_en), 0);
    chk("rst_en_out", 64'(en_out), 0);
    chk("rst_cmen_out", 64'(cmen_out), 0);
    chk("rst_rd_addr", 64'(|rd_addr), 0);

    // Idle data path: zeroed when gating is built in, raw otherwise.
`ifdef SYSTOLIC_FEED_ZERO_GATE_EN
    exp_idle = '0;
`else
    exp_idle = PAT;
`endif
    chk("idle_data_lane3", 64'(data_out[3*DATA_W +: DATA_W]), 64'(exp_idle));

    // Test 1: basic command with accumulator clear.
    begin_cmd(16'h0010, 16'd4, 1'b1);
    wait_to(30);
    chk("t1_rd0", rec_rd0, rng(1, 4));
    chk("t1_rd7", rec_rd7, rng(8, 11));
    chk("t1_en0", rec_en0, rng(2, 5));
    chk("t1_en7", rec_en7, rng(9, 12));
    chk("t1_cm7", rec_cm7, rng(9, 9));
    chk("t1_done", rec_done, rng(13, 13));
    chk("t1_busy", rec_busy, rng(1, 13));
    chk("t1_q_left", 64'(exp_q0.size() + exp_q7.size()), 0);

    // Test 2: zero length goes straight to done.
    begin_cmd(16'h0040, 16'd0, 1'b1);
    wait_to(20);
    chk("t2_rd0", rec_rd0, 0);
    chk("t2_done", rec_done, rng(1, 1));
    chk("t2_busy", rec_busy, rng(1, 1));

    // Test 3: address wrap, no accumulator clear.
    begin_cmd(16'hFFFE, 16'd3, 1'b0);
    wait_to(30);
    chk("t3_rd0", rec_rd0, rng(1, 3));
    chk("t3_cm7", rec_cm7, 0);
    chk("t3_done", rec_done, rng(12, 12));
    chk("t3_q_left", 64'(exp_q0.size() + exp_q7.size()), 0);

    // Test 4: stall during cycles 2-3.
    begin_cmd(16'h0010, 16'd4, 1'b1);
    while (cyc - t0 < 35) begin
      stall = ((cyc - t0) == 2) || ((cyc - t0) == 3);
      tick();
    end
    stall = 1'b0;
    chk("t4_rd0", rec_rd0, rng(1, 1) | rng(4, 6));
    chk("t4_en0", rec_en0, rng(2, 2) | rng(5, 7));
    chk("t4_rd7", rec_rd7, rng(10, 13));
    chk("t4_en7", rec_en7, rng(11, 14));
    chk("t4_cm7", rec_cm7, rng(11, 11));
    chk("t4_done", rec_done, rng(15, 15));
    chk("t4_busy", rec_busy, rng(1, 15));
    chk("t4_q_left", 64'(exp_q0.size() + exp_q7.size()), 0);

    // Test 5a: second start while busy is ignored.
    begin_cmd(16'h0010, 16'd4, 1'b1);
    while (cyc - t0 < 35) begin
      if ((cyc - t0) == 5) begin
        start = 1'b1; base_addr = 16'h0300; len = 16'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("t5_rd0", rec_rd0, rng(1, 4));
    chk("t5_done", rec_done, rng(13, 13));
    chk("t5_q_left", 64'(exp_q0.size() + exp_q7.size()), 0);

    // Test 5b: reset in cycle 6 aborts the command with no done.
    begin_cmd(16'h0010, 16'd4, 1'b1);
    while (cyc - t0 < 40) begin
      rst = ((cyc - t0) == 6);
      tick();
    end
    rst = 1'b0;
    chk("t5b_quiet", rec_any & rng(7, 39), 0);
    chk("t5b_done", rec_done, 0);
    chk("t5b_lane7_unread", 64'(exp_q7.size()), 4);
    exp_q7.delete();
    chk("t5b_q0_left", 64'(exp_q0.size()), 0);

    // Test 6: data path again, after the abort, while idle.
    @(negedge clk);
    chk("idle_data_lane0", 64'(data_out[0 +: DATA_W]), 64'(exp_idle));

    rec_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
